// File: rtl/ime_search_ctrl.sv
// Integer-pel full-search sequencer for the IME 4x4 cost stage: issues a raster of
// candidate MVs, delays their MV cost to line up with the SAD engine, keeps per-block minima.
module ime_search_ctrl #(
    parameter int SR       = 16,
    parameter int MV_W     = 8,
    parameter int LAMBDA_W = 8,
    parameter int MVC_W    = 16,
    parameter int COST_LEN = 16,
    parameter int BLK_NUM  = 16,
    parameter int SAD_LAT  = 2
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          start_i,
    input  logic [MV_W-1:0]               pmv_x_i,
    input  logic [MV_W-1:0]               pmv_y_i,
    input  logic [LAMBDA_W-1:0]           lambda_i,
    input  logic                          cand_rdy_i,
    output logic                          cand_v_o,
    output logic [MV_W-1:0]               cand_mv_x_o,
    output logic [MV_W-1:0]               cand_mv_y_o,
    output logic [MVC_W-1:0]              mv_cost_o,
    output logic                          sad4x4_v_o,
    input  logic [BLK_NUM*COST_LEN-1:0]   cost4x4_i,
    output logic [BLK_NUM*COST_LEN-1:0]   best_cost_o,
    output logic [BLK_NUM*2*MV_W-1:0]     best_mv_o,
    output logic                          busy_o,
    output logic                          done_o
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic                v;
        logic [2*MV_W-1:0]   mv;
        logic [MVC_W-1:0]    cost;
    } pipe_t;

    localparam int PROD_W = LAMBDA_W + MV_W + 2;
    localparam int WIDE_W = (PROD_W > MVC_W) ? PROD_W : MVC_W;
    localparam int DCNT_W = $clog2(SAD_LAT + 1) + 1;
    localparam logic [MV_W-1:0] MV_LO = MV_W'(-SR);
    localparam logic [MV_W-1:0] MV_HI = MV_W'(SR - 1);

    state_t                 state_q, state_d;
    logic [MV_W-1:0]        x_q, x_d, y_q, y_d;
    logic [MV_W-1:0]        pmv_x_q, pmv_y_q;
    logic [LAMBDA_W-1:0]    lambda_q;
    logic [DCNT_W-1:0]      dcnt_q, dcnt_d;
    logic                   start_acc;
    logic                   hs;

    pipe_t                  pipe_q [SAD_LAT];
    logic                   cmp_v_q;
    logic [2*MV_W-1:0]      cmp_mv_q;

    logic [COST_LEN-1:0]    best_cost_q [BLK_NUM];
    logic [COST_LEN-1:0]    best_cost_d [BLK_NUM];
    logic [2*MV_W-1:0]      best_mv_q   [BLK_NUM];
    logic [2*MV_W-1:0]      best_mv_d   [BLK_NUM];

    logic [MV_W:0]          dx, dy, adx, ady;
    logic [MV_W+1:0]        dsum;
    logic [WIDE_W-1:0]      prod;
    logic [MVC_W-1:0]       mvc;

    assign hs = (state_q == S_SCAN) && cand_rdy_i;

    // NOTE: every always_comb assigns all its outputs a default first, so no path
    // leaves a signal unassigned and no latch can be inferred.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        dcnt_d    = dcnt_q;
        start_acc = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    start_acc = 1'b1;
                    x_d       = MV_LO;
                    y_d       = MV_LO;
                    state_d   = S_SCAN;
                end
            end
            S_SCAN: begin
                dcnt_d = '0;
                if (cand_rdy_i) begin
                    if (x_q == MV_HI) begin
                        if (y_q == MV_HI) begin
                            state_d = S_DRAIN;
                        end else begin
                            x_d = MV_LO;
                            y_d = y_q + 1'b1;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                // Hold until the last issued candidate has reached the compare stage.
                if (dcnt_q == DCNT_W'(SAD_LAT)) state_d = S_DONE;
                else                             dcnt_d  = dcnt_q + 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // MV cost on the issued candidate: sign-extended differences, then saturate the product.
    always_comb begin
        dx   = {x_q[MV_W-1], x_q} - {pmv_x_q[MV_W-1], pmv_x_q};
        dy   = {y_q[MV_W-1], y_q} - {pmv_y_q[MV_W-1], pmv_y_q};
        adx  = dx[MV_W] ? (~dx + 1'b1) : dx;
        ady  = dy[MV_W] ? (~dy + 1'b1) : dy;
        dsum = {1'b0, adx} + {1'b0, ady};
        prod = WIDE_W'(lambda_q) * WIDE_W'(dsum);
        mvc  = prod[MVC_W-1:0];
        if (prod > WIDE_W'({MVC_W{1'b1}})) mvc = '1;
    end

    always_comb begin
        best_cost_d = best_cost_q;
        best_mv_d   = best_mv_q;
        for (int i = 0; i < BLK_NUM; i++) begin
            if (start_acc) begin
                best_cost_d[i] = '1;
                best_mv_d[i]   = '0;
            end else if (cmp_v_q && (cost4x4_i[i*COST_LEN +: COST_LEN] < best_cost_q[i])) begin
                // Strict less-than: a tie keeps the earlier raster candidate.
                best_cost_d[i] = cost4x4_i[i*COST_LEN +: COST_LEN];
                best_mv_d[i]   = cmp_mv_q;
            end
        end
    end

    // NOTE: sequential state is written only with non-blocking assignments so every
    // register samples its inputs from before the clock edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            dcnt_q   <= '0;
            pmv_x_q  <= '0;
            pmv_y_q  <= '0;
            lambda_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dcnt_q  <= dcnt_d;
            if (start_acc) begin
                pmv_x_q  <= pmv_x_i;
                pmv_y_q  <= pmv_y_i;
                lambda_q <= lambda_i;
            end
        end
    end

    // The last pipe stage drives sad4x4_v_o/mv_cost_o; cmp_* mirrors the ime_cost4x4 register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < SAD_LAT; k++) pipe_q[k] <= '0;
            cmp_v_q  <= 1'b0;
            cmp_mv_q <= '0;
        end else begin
            pipe_q[0] <= '{v: hs, mv: {y_q, x_q}, cost: mvc};
            for (int k = 1; k < SAD_LAT; k++) pipe_q[k] <= pipe_q[k-1];
            cmp_v_q  <= pipe_q[SAD_LAT-1].v;
            cmp_mv_q <= pipe_q[SAD_LAT-1].mv;
        end
    end

    // NOTE: the result arrays are reset like any other register because they drive
    // outputs directly and must read 0 out of reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < BLK_NUM; i++) begin
                best_cost_q[i] <= '0;
                best_mv_q[i]   <= '0;
            end
        end else begin
            best_cost_q <= best_cost_d;
            best_mv_q   <= best_mv_d;
        end
    end

    for (genvar g = 0; g < BLK_NUM; g++) begin : g_pack
        assign best_cost_o[g*COST_LEN +: COST_LEN] = best_cost_q[g];
        assign best_mv_o[g*2*MV_W +: 2*MV_W]       = best_mv_q[g];
    end

    assign cand_v_o    = (state_q == S_SCAN);
    assign cand_mv_x_o = x_q;
    assign cand_mv_y_o = y_q;
    assign sad4x4_v_o  = pipe_q[SAD_LAT-1].v;
    assign mv_cost_o   = pipe_q[SAD_LAT-1].cost;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);

endmodule

// File: tb/tb_ime_search_ctrl.sv
// Directed bench for ime_search_ctrl with a small ime_cost4x4 stand-in (SAD pattern + mv_cost, one register).
module tb_ime_search_ctrl;

    localparam int SR       = 2;
    localparam int MV_W     = 8;
    localparam int LAMBDA_W = 8;
    localparam int MVC_W    = 8;
    localparam int COST_LEN = 16;
    localparam int BLK_NUM  = 16;
    localparam int SAD_LAT  = 2;
    localparam int NCAND    = (2*SR) * (2*SR);
    localparam int MVC_MAX  = (1 << MVC_W) - 1;

    logic                         clk = 1'b0;
    logic                         rstn = 1'b0;
    logic                         start_i = 1'b0;
    logic [MV_W-1:0]              pmv_x_i = '0;
    logic [MV_W-1:0]              pmv_y_i = '0;
    logic [LAMBDA_W-1:0]          lambda_i = '0;
    logic                         cand_rdy_i = 1'b1;
    logic                         cand_v_o;
    logic [MV_W-1:0]              cand_mv_x_o, cand_mv_y_o;
    logic [MVC_W-1:0]             mv_cost_o;
    logic                         sad4x4_v_o;
    logic [BLK_NUM*COST_LEN-1:0]  cost4x4_i = '0;
    logic [BLK_NUM*COST_LEN-1:0]  best_cost_o;
    logic [BLK_NUM*2*MV_W-1:0]    best_mv_o;
    logic                         busy_o, done_o;

    always #5 clk = ~clk;

    ime_search_ctrl #(
        .SR(SR), .MV_W(MV_W), .LAMBDA_W(LAMBDA_W), .MVC_W(MVC_W),
        .COST_LEN(COST_LEN), .BLK_NUM(BLK_NUM), .SAD_LAT(SAD_LAT)
    ) dut (
        .clk(clk), .rstn(rstn), .start_i(start_i),
        .pmv_x_i(pmv_x_i), .pmv_y_i(pmv_y_i), .lambda_i(lambda_i),
        .cand_rdy_i(cand_rdy_i), .cand_v_o(cand_v_o),
        .cand_mv_x_o(cand_mv_x_o), .cand_mv_y_o(cand_mv_y_o),
        .mv_cost_o(mv_cost_o), .sad4x4_v_o(sad4x4_v_o), .cost4x4_i(cost4x4_i),
        .best_cost_o(best_cost_o), .best_mv_o(best_mv_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Search configuration the model expects (set only by the stimulus).
    int m_lambda = 0, m_px = 0, m_py = 0, m_mode = 0;
    bit stall_en = 1'b0;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // mode 0: flat SAD 100; mode 1: block 5 minimum at (1,-1), others at (-2,0); else flat 77.
    function automatic int sad_of(input int blk, input int x, input int y);
        int tx, ty;
        case (m_mode)
            0: return 100;
            1: begin
                tx = (blk == 5) ? 1 : -2;
                ty = (blk == 5) ? -1 : 0;
                return 50 + 10 * (iabs(x - tx) + iabs(y - ty));
            end
            default: return 77;
        endcase
    endfunction

    function automatic int mvc_of(input int x, input int y);
        int c;
        c = m_lambda * (iabs(x - m_px) + iabs(y - m_py));
        return (c > MVC_MAX) ? MVC_MAX : c;
    endfunction

    typedef struct { int x; int y; } mv_t;
    mv_t hs_q[$];
    int  hs_idx  = 0;
    int  sv_cnt  = 0;
    int  done_cnt = 0;
    int  cyc     = 0;
    bit  pend_v  = 1'b0;
    logic [BLK_NUM*COST_LEN-1:0] pend = '0;

    always @(posedge clk) cyc++;

    // ime_cost4x4 stand-in: registers the cost vector one cycle after sad4x4_v_o.
    always @(posedge clk) if (pend_v) cost4x4_i <= pend;

    always @(posedge clk) begin
        #1;
        cand_rdy_i = stall_en ? ($urandom_range(0, 99) >= 40) : 1'b1;
    end

    always @(negedge clk) begin
        mv_t m;
        int  idx, ex, ey;
        if (!rstn) begin
            hs_q.delete();
            hs_idx = 0;
            pend_v = 1'b0;
        end else begin
            pend_v = 1'b0;
            if (sad4x4_v_o) begin
                sv_cnt++;
                if (hs_q.size() == 0) begin
                    check("sad_v_without_candidate", 1, 0);
                end else begin
                    m = hs_q.pop_front();
                    check("mv_cost", 32'(mv_cost_o), mvc_of(m.x, m.y));
                    for (int b = 0; b < BLK_NUM; b++)
                        pend[b*COST_LEN +: COST_LEN] = COST_LEN'(sad_of(b, m.x, m.y) + int'(mv_cost_o));
                    pend_v = 1'b1;
                end
            end
            if (cand_v_o && cand_rdy_i) begin
                idx = hs_idx % NCAND;
                ex  = -SR + idx % (2*SR);
                ey  = -SR + idx / (2*SR);
                m.x = int'($signed(cand_mv_x_o));
                m.y = int'($signed(cand_mv_y_o));
                check("cand_x", m.x, ex);
                check("cand_y", m.y, ey);
                hs_q.push_back(m);
                hs_idx++;
            end
            if (done_o) done_cnt++;
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_cand_v"}, cand_v_o, 0);
        check({tag, "_cand_mv"}, {cand_mv_y_o, cand_mv_x_o}, 0);
        check({tag, "_sad_v"}, sad4x4_v_o, 0);
        check({tag, "_mv_cost"}, mv_cost_o, 0);
        check({tag, "_best_cost_zero"}, (best_cost_o == '0), 1);
        check({tag, "_best_mv_zero"}, (best_mv_o == '0), 1);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
    endtask

    task automatic do_start(input int lam, input int px, input int py);
        start_i  = 1'b1;
        lambda_i = LAMBDA_W'(lam);
        pmv_x_i  = MV_W'(px);
        pmv_y_i  = MV_W'(py);
        @(posedge clk); #1;
        start_i  = 1'b0;
    endtask

    task automatic run_search(input string name, input int lam, input int px, input int py,
                              input int mode, input bit stall, input bit poke,
                              input int cost5, input int mv5, input int cost_o, input int mv_o);
        int  s_cyc, sv0, dn0;
        bit  seen;
        m_lambda = lam; m_px = px; m_py = py; m_mode = mode;
        sv0 = sv_cnt;
        dn0 = done_cnt;
        @(posedge clk); #1;
        stall_en = stall;
        s_cyc = cyc;
        do_start(lam, px, py);
        if (poke) begin
            repeat (3) @(posedge clk);
            #1;
            do_start(9, 5, -3);
        end
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            if (done_o) seen = 1'b1;
        end
        check({name, "_done_seen"}, seen, 1);
        if (seen) begin
            if (!stall) check({name, "_latency"}, cyc - s_cyc, NCAND + SAD_LAT + 2);
            check({name, "_busy_at_done"}, busy_o, 1);
            for (int b = 0; b < BLK_NUM; b++) begin
                check($sformatf("%s_cost[%0d]", name, b), best_cost_o[b*COST_LEN +: COST_LEN],
                      (b == 5) ? cost5 : cost_o);
                check($sformatf("%s_mv[%0d]", name, b), best_mv_o[b*2*MV_W +: 2*MV_W],
                      (b == 5) ? mv5 : mv_o);
            end
            @(negedge clk);
            check({name, "_busy_after"}, busy_o, 0);
            check({name, "_done_pulse"}, done_o, 0);
            check({name, "_cost5_stable"}, best_cost_o[5*COST_LEN +: COST_LEN], cost5);
        end
        stall_en = 1'b0;
        check({name, "_sad_v_count"}, sv_cnt - sv0, NCAND);
        check({name, "_done_count"}, done_cnt - dn0, 1);
    endtask

    initial begin
        int dn0;
        #3;
        check_outputs_zero("reset");
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        // {y,x} encodings: (0,0)=0000, x=1,y=-1 -> FF01, x=-2,y=0 -> 00FE, (-2,-2) -> FEFE.
        run_search("basic",  4,   0,    0, 0, 1'b0, 1'b0, 100, 16'h0000, 100, 16'h0000);
        run_search("minpos", 0,   0,    0, 1, 1'b0, 1'b0,  50, 16'hFF01,  50, 16'h00FE);
        run_search("tie",    0,   0,    0, 2, 1'b0, 1'b0,  77, 16'hFEFE,  77, 16'hFEFE);
        run_search("stall",  0,   0,    0, 1, 1'b1, 1'b1,  50, 16'hFF01,  50, 16'h00FE);
        run_search("sat",  255, 127, -128, 0, 1'b0, 1'b0, 355, 16'hFEFE, 355, 16'hFEFE);

        // Abort mid-scan with reset: outputs clear at once and no done follows.
        m_lambda = 4; m_px = 0; m_py = 0; m_mode = 0;
        @(posedge clk); #1;
        do_start(4, 0, 0);
        repeat (5) @(posedge clk);
        #1;
        check("abort_busy_before", busy_o, 1);
        dn0 = done_cnt;
        rstn = 1'b0;
        #1;
        check_outputs_zero("abort_now");
        @(negedge clk);
        check_outputs_zero("abort_next");
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_no_done", done_cnt - dn0, 0);
        check("abort_idle", busy_o, 0);

        run_search("post_rst", 4, 0, 0, 0, 1'b0, 1'b0, 100, 16'h0000, 100, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ime_search_ctrl.md
Name: ime_search_ctrl

Overview:
- Sequences one integer-pel full search for the IME 4x4 cost stage.
- Walks a raster of candidate MVs, computes each candidate's MV cost, and aligns `mv_cost` and the SAD-valid strobe with the SAD engine latency feeding `ime_cost4x4`.
- Takes the registered 16-block cost vector back and keeps the minimum cost and winning MV per 4x4 block.
- Sits between the MB-level IME FSM (`start`/`done`) and the SAD array + `ime_cost4x4` pair.

Parameters:
- SR, 16, search range; candidates x,y in [-SR, SR-1]; (2*SR)^2 candidates.
- MV_W, 8, signed MV component width; must hold -SR..SR-1 and pmv.
- LAMBDA_W, 8, lambda width (unsigned).
- MVC_W, 16, mv cost width (`MV_COST_BITS`); result saturates.
- COST_LEN, 16, per-block cost width (`COST4X4_LEN`).
- BLK_NUM, 16, number of 4x4 blocks (`SAD4X4_NUM`).
- SAD_LAT, 2, cycles from `cand_v_o` to SAD valid at the `ime_cost4x4` input (>=1).

Ports:
- clk  in  1  clock
- rstn  in  1  async active-low reset
- start_i  in  1  start search pulse; ignored while busy_o=1
- pmv_x_i, pmv_y_i  in  MV_W each  signed predicted MV; sampled on accepted start
- lambda_i  in  LAMBDA_W  sampled on accepted start
- cand_rdy_i  in  1  SAD engine can accept a candidate this cycle
- cand_v_o  out  1  candidate issued (handshake completes when cand_v_o & cand_rdy_i)
- cand_mv_x_o, cand_mv_y_o  out  MV_W each  signed candidate MV
- mv_cost_o  out  MVC_W  to `ime_cost4x4.mv_cost_i`, aligned with sad4x4_v_o
- sad4x4_v_o  out  1  to `ime_cost4x4.sad4x4_v_i`
- cost4x4_i  in  BLK_NUM*COST_LEN  from `ime_cost4x4.cost4x4_o`
- best_cost_o  out  BLK_NUM*COST_LEN  per-block minimum cost, block i at [(i+1)*COST_LEN-1 : i*COST_LEN]
- best_mv_o  out  BLK_NUM*2*MV_W  per-block winner; block i = {y, x}, x in the low half
- busy_o  out  1  high in SCAN/DRAIN/DONE
- done_o  out  1  one-cycle pulse; results are valid and stable from this cycle until the next accepted start

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - Every output is 0; internal pipe valids, counters and latched pmv/lambda are 0.
  - Reset mid-search aborts the search; no done_o is produced.
- FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - start_i=1 latches pmv and lambda, sets x=y=-SR, clears all best_cost to all-ones and best_mv to 0, then goes to SCAN.
- SCAN:
  - cand_v_o=1 every cycle, with cand_mv = current (x,y).
  - On handshake, x increments. When x=SR-1, x wraps to -SR and y increments.
  - On handshake at (SR-1,SR-1), go to DRAIN.
  - cand_rdy_i=0 holds the candidate and counters; that cycle inserts a bubble (valid=0) into the pipe.
- MV cost:
  - Computed combinationally on the issued candidate: lambda*(|x-pmv_x|+|y-pmv_y|).
  - Differences use MV_W+1 bits; the sum uses MV_W+2 bits.
  - The product saturates to 2^MVC_W-1.
- Delay pipe (always advancing):
  - Stage depth SAD_LAT carries {valid, mv, mv_cost}.
  - The stage-SAD_LAT outputs are registered as sad4x4_v_o and mv_cost_o, so both appear exactly SAD_LAT cycles after the handshake.
  - A further one-stage delay holds {valid, mv} to match the `ime_cost4x4` register.
- Compare:
  - When the final-stage valid=1, for each block i: if cost4x4_i[i] < best_cost[i] (strict), update best_cost[i] and best_mv[i].
  - Ties keep the earlier raster candidate.
  - All 16 blocks compare in parallel, in one cycle.
- DRAIN:
  - cand_v_o=0.
  - A counter waits SAD_LAT+1 cycles so the last candidate is compared, then goes to DONE.
- DONE:
  - done_o=1 for one cycle, then go to IDLE.
  - busy_o drops in the IDLE cycle that follows.
- start_i in any non-IDLE state is ignored.
- Latency with no stalls: the done_o cycle is (2*SR)^2 + SAD_LAT + 2 cycles after the start cycle.

Test Plan:
- SR=2, cand_rdy_i=1, pmv=(0,0), lambda=4, model returns cost=SAD+mv_cost with SAD all 100 -> 16 candidates in raster (-2,-2)..(1,1); best_mv=(0,0) for all blocks; best_cost=100; done_o exactly 16+SAD_LAT+2 cycles after start.
- SR=2, block 5 SAD minimum at (1,-1), other blocks at (-2,0), lambda=0 -> best_mv[5]=(1,-1), all other blocks (-2,0), costs match the model.
- Tie: all SADs equal, lambda=0 -> every block selects the first candidate (-2,-2).
- Random cand_rdy_i low about 40% of cycles -> the candidate sequence has no skips or repeats; mv_cost_o and sad4x4_v_o count equals 16; results identical to the no-stall run.
- Saturation: lambda=255, pmv=(127,-128), MVC_W=8 -> mv_cost_o=255 for every candidate.
- Assert rstn low mid-SCAN -> all outputs 0 next cycle, no done_o; start_i pulsed while busy is ignored; a new start after reset completes normally.
